// File: rtl/geofence_pkg.sv
// ----------------------------------------------------------------------------
// geofence_pkg
// Shared definitions for the geofence point-stream harness.
//   COORD_W     : width of one X or Y coordinate
//   PTS_PER_OBJ : points per test object (1 target + 6 fence vertices)
//   READ_SLOTS  : sample slots the receiver reads per object (points + 1 pad)
//   drv_state_e : stimulus driver state encoding
// ----------------------------------------------------------------------------
package geofence_pkg;

    localparam int COORD_W     = 10;
    localparam int PTS_PER_OBJ = 7;
    localparam int READ_SLOTS  = 8;

    typedef enum logic [1:0] {
        SEND = 2'd0,
        PAD  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } drv_state_e;

endpackage

// File: rtl/geofence_stim_driver_if.sv
// ----------------------------------------------------------------------------
// geofence_stim_driver_if
// Point-stream link between the stimulus driver and a geofence receiver.
//   X, Y      : coordinate of the current sample slot (driver -> receiver)
//   valid     : one-cycle result strobe (receiver -> driver)
//   is_inside : receiver verdict, meaningful only while valid=1
// Modports:
//   master : the stimulus driver side
//   slave  : the geofence receiver side
// ----------------------------------------------------------------------------
interface geofence_stim_driver_if;
    import geofence_pkg::*;

    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
    logic               valid;
    logic               is_inside;

    modport master (
        output X,
        output Y,
        input  valid,
        input  is_inside
    );

    modport slave (
        input  X,
        input  Y,
        output valid,
        output is_inside
    );

endinterface

// File: rtl/geofence_stim_driver.sv
// ----------------------------------------------------------------------------
// geofence_stim_driver
// Transmit side of the geofence point stream. For each object it walks the
// pattern store (7 points), inserts one pad slot, then waits for the
// receiver's result strobe and compares is_inside against the expected bit.
// Keeps saturating pass/fail statistics and sticky error flags.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high
//   pat_addr   : point address into the pattern store (obj*7+idx)
//   pat_x/y    : point coordinates at pat_addr (asynchronous ROM)
//   exp_addr   : object index into the expected-result table
//   exp_inside : expected verdict at exp_addr (asynchronous ROM)
//   rx         : point-stream link to the receiver (master side)
//   done       : high from entering DONE until reset
//   err_cnt    : verdict mismatches, saturating
//   obj_cnt    : objects checked, saturating
//   timeout    : sticky, no result strobe within TIMEOUT wait cycles
//   proto_err  : sticky, result strobe seen outside WAIT
// ----------------------------------------------------------------------------
module geofence_stim_driver
    import geofence_pkg::*;
#(
    parameter  int NUM_OBJ = 16,
    parameter  int TIMEOUT = 32,
    parameter  int ADDR_W  = 8,
    localparam int CNT_W   = $clog2(NUM_OBJ + 1)
) (
    input  logic                   clk,
    input  logic                   reset,

    output logic [ADDR_W-1:0]      pat_addr,
    input  logic [COORD_W-1:0]     pat_x,
    input  logic [COORD_W-1:0]     pat_y,

    output logic [ADDR_W-1:0]      exp_addr,
    input  logic                   exp_inside,

    geofence_stim_driver_if.master rx,

    output logic                   done,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       obj_cnt,
    output logic                   timeout,
    output logic                   proto_err
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam logic [ADDR_W-1:0] LAST_OBJ  = ADDR_W'(NUM_OBJ - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(PTS_PER_OBJ - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_OBJ);

    drv_state_e        state_r;
    logic [2:0]        idx_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    // Sequencer: point walk, pad slot, result wait and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= SEND;
            idx_r      <= 3'd0;
            wait_cnt_r <= {WAIT_W{1'b0}};
            pat_addr   <= {ADDR_W{1'b0}};
            exp_addr   <= {ADDR_W{1'b0}};
            done       <= 1'b0;
            err_cnt    <= {CNT_W{1'b0}};
            obj_cnt    <= {CNT_W{1'b0}};
            timeout    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (state_r)
                SEND: begin
                    // The address stops on the last point of the object so it
                    // never runs past the final pattern entry; the step to the
                    // next object happens when the result is accepted.
                    if (idx_r == LAST_IDX) begin
                        state_r <= PAD;
                    end else begin
                        idx_r    <= idx_r + 3'd1;
                        pat_addr <= pat_addr + ADDR_W'(1);
                    end
                    // A strobe here is flagged but does not disturb the stream.
                    if (rx.valid) begin
                        proto_err <= 1'b1;
                    end
                end

                PAD: begin
                    state_r    <= WAIT;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                    if (rx.valid) begin
                        proto_err <= 1'b1;
                    end
                end

                WAIT: begin
                    // A strobe on the final wait cycle still counts as a result.
                    if (rx.valid) begin
                        if (obj_cnt != CNT_MAX) begin
                            obj_cnt <= obj_cnt + CNT_W'(1);
                        end
                        if ((rx.is_inside != exp_inside) && (err_cnt != CNT_MAX)) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        if (exp_addr == LAST_OBJ) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            // Receiver re-enters its read phase right after
                            // the strobe, so the next object starts at once.
                            state_r  <= SEND;
                            idx_r    <= 3'd0;
                            exp_addr <= exp_addr + ADDR_W'(1);
                            pat_addr <= pat_addr + ADDR_W'(1);
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end

                DONE: begin
                    // Everything is frozen; a late strobe is only flagged.
                    if (rx.valid) begin
                        proto_err <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: park safely with done raised.
                    state_r <= DONE;
                    done    <= 1'b1;
                end
            endcase
        end
    end

    // Coordinate mux. The pattern store is asynchronous and the receiver
    // samples on the first edge after reset release, so the point for the
    // registered pat_addr must reach X/Y in the same cycle.
    always_comb begin
        if (state_r == SEND) begin
            rx.X = pat_x;
            rx.Y = pat_y;
        end else begin
            rx.X = {COORD_W{1'b0}};
            rx.Y = {COORD_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_geofence_stim_driver.sv
module tb_geofence_stim_driver;
    import geofence_pkg::*;

    localparam int NOBJ = 2;
    localparam int TOUT = 20;
    localparam int AW   = 8;
    localparam int CW   = $clog2(NOBJ + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [AW-1:0]      pat_addr;
    logic [COORD_W-1:0] pat_x;
    logic [COORD_W-1:0] pat_y;
    logic [AW-1:0]      exp_addr;
    logic               exp_inside;
    logic               done;
    logic [CW-1:0]      err_cnt;
    logic [CW-1:0]      obj_cnt;
    logic               timeout;
    logic               proto_err;

    // pattern store and expected table (randomised per test)
    logic [COORD_W-1:0] rom_x [0:15];
    logic [COORD_W-1:0] rom_y [0:15];
    logic               exp_rom [0:3];

    // reference model of the status outputs
    int   m_err;
    int   m_obj;
    logic m_done;
    logic m_to;
    logic m_proto;

    int n_vec = 0;
    int n_err = 0;

    geofence_stim_driver_if gif();

    assign pat_x      = rom_x[pat_addr[3:0]];
    assign pat_y      = rom_y[pat_addr[3:0]];
    assign exp_inside = exp_rom[exp_addr[1:0]];

    geofence_stim_driver #(
        .NUM_OBJ (NOBJ),
        .TIMEOUT (TOUT),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pat_addr   (pat_addr),
        .pat_x      (pat_x),
        .pat_y      (pat_y),
        .exp_addr   (exp_addr),
        .exp_inside (exp_inside),
        .rx         (gif.master),
        .done       (done),
        .err_cnt    (err_cnt),
        .obj_cnt    (obj_cnt),
        .timeout    (timeout),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 16; i++) begin
            rom_x[i] = COORD_W'($urandom);
            rom_y[i] = COORD_W'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            exp_rom[i] = 1'($urandom);
        end
    endtask

    task automatic model_clear();
        m_err   = 0;
        m_obj   = 0;
        m_done  = 1'b0;
        m_to    = 1'b0;
        m_proto = 1'b0;
    endtask

    task automatic do_reset();
        gif.valid     = 1'b0;
        gif.is_inside = 1'b0;
        reset         = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
    endtask

    // Walk the 8 read slots of object o; optionally pulse valid in one slot.
    task automatic stream_object(input int o, input int pulse_slot);
        logic [COORD_W-1:0] ex;
        logic [COORD_W-1:0] ey;
        int                 ea;
        for (int s = 0; s < READ_SLOTS; s++) begin
            if (s < PTS_PER_OBJ) begin
                ex = rom_x[o * PTS_PER_OBJ + s];
                ey = rom_y[o * PTS_PER_OBJ + s];
                ea = o * PTS_PER_OBJ + s;
            end else begin
                ex = '0;
                ey = '0;
                ea = o * PTS_PER_OBJ + PTS_PER_OBJ - 1;
            end
            n_vec++;
            if (gif.X !== ex || gif.Y !== ey) begin
                n_err++;
                $display("FAIL slot_xy obj%0d slot%0d: got %0d/%0d, required %0d/%0d",
                         o, s, gif.X, gif.Y, ex, ey);
            end
            n_vec++;
            if (pat_addr !== AW'(ea) || exp_addr !== AW'(o)) begin
                n_err++;
                $display("FAIL slot_addr obj%0d slot%0d: got pat %0d exp %0d, required pat %0d exp %0d",
                         o, s, pat_addr, exp_addr, ea, o);
            end
            if (s == pulse_slot) begin
                gif.valid     = 1'b1;
                gif.is_inside = 1'($urandom);
                m_proto       = 1'b1;
            end
            step();
            gif.valid = 1'b0;
        end
    endtask

    // Called on the first WAIT cycle; strobe the verdict after lat idle cycles.
    task automatic respond(input int o, input int lat, input logic verdict);
        for (int c = 0; c < lat; c++) begin
            n_vec++;
            if (done !== 1'b0 || gif.X !== '0) begin
                n_err++;
                $display("FAIL wait_idle obj%0d cyc%0d: got done %0b X %0d, required done 0 X 0",
                         o, c, done, gif.X);
            end
            step();
        end
        gif.valid     = 1'b1;
        gif.is_inside = verdict;
        step();
        gif.valid     = 1'b0;
        gif.is_inside = 1'b0;
        m_obj++;
        if (verdict != exp_rom[o]) m_err++;
        if (o == NOBJ - 1) m_done = 1'b1;
        n_vec++;
        if (obj_cnt !== CW'(m_obj) || err_cnt !== CW'(m_err)) begin
            n_err++;
            $display("FAIL result_cnt obj%0d: got obj %0d err %0d, required obj %0d err %0d",
                     o, obj_cnt, err_cnt, m_obj, m_err);
        end
    endtask

    task automatic test_reset();
        load_rom();
        do_reset();
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !== '0 ||
            pat_addr !== '0 || exp_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state: got done %0b to %0b pe %0b err %0d obj %0d pa %0d ea %0d, required all 0",
                     done, timeout, proto_err, err_cnt, obj_cnt, pat_addr, exp_addr);
        end
        n_vec++;
        if (gif.X !== rom_x[0] || gif.Y !== rom_y[0]) begin
            n_err++;
            $display("FAIL reset_xy: got %0d/%0d, required %0d/%0d", gif.X, gif.Y, rom_x[0], rom_y[0]);
        end
    endtask

    task automatic test_normal();
        load_rom();
        do_reset();
        stream_object(0, -1);
        respond(0, 12, exp_rom[0]);
        stream_object(1, -1);
        respond(1, 12, exp_rom[1]);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({done, timeout, proto_err, err_cnt, obj_cnt} !==
                {1'b1, 1'b0, 1'b0, CW'(0), CW'(NOBJ)}) begin
                n_err++;
                $display("FAIL normal_status: got done %0b to %0b pe %0b err %0d obj %0d, required 1 0 0 0 %0d",
                         done, timeout, proto_err, err_cnt, obj_cnt, NOBJ);
            end
            n_vec++;
            if (gif.X !== '0 || gif.Y !== '0 || pat_addr !== AW'(NOBJ * 7 - 1) || exp_addr !== AW'(NOBJ - 1)) begin
                n_err++;
                $display("FAIL done_frozen: got X %0d Y %0d pa %0d ea %0d, required 0 0 %0d %0d",
                         gif.X, gif.Y, pat_addr, exp_addr, NOBJ * 7 - 1, NOBJ - 1);
            end
            step();
        end
    endtask

    task automatic test_mismatch();
        load_rom();
        do_reset();
        stream_object(0, -1);
        respond(0, $urandom_range(0, TOUT - 1), exp_rom[0]);
        stream_object(1, -1);
        respond(1, $urandom_range(0, TOUT - 1), ~exp_rom[1]);
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !== {1'b1, 1'b0, 1'b0, CW'(1), CW'(2)}) begin
            n_err++;
            $display("FAIL mismatch_status: got done %0b to %0b pe %0b err %0d obj %0d, required 1 0 0 1 2",
                     done, timeout, proto_err, err_cnt, obj_cnt);
        end
    endtask

    task automatic test_timeout();
        load_rom();
        do_reset();
        stream_object(0, -1);
        for (int c = 0; c < TOUT; c++) begin
            n_vec++;
            if (done !== 1'b0 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_early cyc%0d: got done %0b timeout %0b, required 0 0", c, done, timeout);
            end
            step();
        end
        n_vec++;
        if ({done, timeout, proto_err, obj_cnt} !== {1'b1, 1'b1, 1'b0, CW'(0)}) begin
            n_err++;
            $display("FAIL timeout_status: got done %0b to %0b pe %0b obj %0d, required 1 1 0 0",
                     done, timeout, proto_err, obj_cnt);
        end
        // a strobe after DONE only raises proto_err
        gif.valid     = 1'b1;
        gif.is_inside = ~exp_rom[0];
        step();
        gif.valid = 1'b0;
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !== {1'b1, 1'b1, 1'b1, CW'(0), CW'(0)}) begin
            n_err++;
            $display("FAIL done_valid: got done %0b to %0b pe %0b err %0d obj %0d, required 1 1 1 0 0",
                     done, timeout, proto_err, err_cnt, obj_cnt);
        end
    endtask

    task automatic test_late_valid();
        logic b0;
        logic b1;
        load_rom();
        do_reset();
        b0 = 1'($urandom);
        b1 = 1'($urandom);
        stream_object(0, -1);
        respond(0, TOUT - 1, b0);
        stream_object(1, -1);
        respond(1, TOUT - 1, b1);
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !==
            {m_done, m_to, m_proto, CW'(m_err), CW'(m_obj)}) begin
            n_err++;
            $display("FAIL late_valid: got done %0b to %0b pe %0b err %0d obj %0d, required %0b %0b %0b %0d %0d",
                     done, timeout, proto_err, err_cnt, obj_cnt, m_done, m_to, m_proto, m_err, m_obj);
        end
    endtask

    task automatic test_proto_err();
        load_rom();
        do_reset();
        stream_object(0, 3);
        n_vec++;
        if (proto_err !== 1'b1 || obj_cnt !== CW'(0)) begin
            n_err++;
            $display("FAIL proto_send: got pe %0b obj %0d, required 1 0", proto_err, obj_cnt);
        end
        respond(0, $urandom_range(0, TOUT - 1), 1'($urandom));
        stream_object(1, 7);
        respond(1, $urandom_range(0, TOUT - 1), 1'($urandom));
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !==
            {m_done, m_to, m_proto, CW'(m_err), CW'(m_obj)}) begin
            n_err++;
            $display("FAIL proto_status: got done %0b to %0b pe %0b err %0d obj %0d, required %0b %0b %0b %0d %0d",
                     done, timeout, proto_err, err_cnt, obj_cnt, m_done, m_to, m_proto, m_err, m_obj);
        end
    endtask

    task automatic test_reset_mid();
        load_rom();
        do_reset();
        stream_object(0, -1);
        respond(0, 5, ~exp_rom[0]);
        stream_object(1, -1);
        step();
        step();
        reset = 1'b1;
        #1;
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !== '0 ||
            pat_addr !== '0 || exp_addr !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got done %0b to %0b pe %0b err %0d obj %0d pa %0d ea %0d, required all 0",
                     done, timeout, proto_err, err_cnt, obj_cnt, pat_addr, exp_addr);
        end
        step();
        reset = 1'b0;
        model_clear();
        stream_object(0, -1);
        respond(0, $urandom_range(0, TOUT - 1), exp_rom[0]);
        stream_object(1, -1);
        respond(1, $urandom_range(0, TOUT - 1), exp_rom[1]);
        n_vec++;
        if ({done, timeout, proto_err, err_cnt, obj_cnt} !== {1'b1, 1'b0, 1'b0, CW'(0), CW'(2)}) begin
            n_err++;
            $display("FAIL reset_rerun: got done %0b to %0b pe %0b err %0d obj %0d, required 1 0 0 0 2",
                     done, timeout, proto_err, err_cnt, obj_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            load_rom();
            do_reset();
            for (int o = 0; o < NOBJ; o++) begin
                stream_object(o, -1);
                respond(o, $urandom_range(0, TOUT - 1), 1'($urandom));
            end
            n_vec++;
            if ({done, timeout, proto_err, err_cnt, obj_cnt} !==
                {m_done, m_to, m_proto, CW'(m_err), CW'(m_obj)}) begin
                n_err++;
                $display("FAIL b2b_run%0d: got done %0b to %0b pe %0b err %0d obj %0d, required %0b %0b %0b %0d %0d",
                         r, done, timeout, proto_err, err_cnt, obj_cnt, m_done, m_to, m_proto, m_err, m_obj);
            end
        end
    endtask

    initial begin
        gif.valid     = 1'b0;
        gif.is_inside = 1'b0;
        model_clear();
        test_reset();
        test_normal();
        test_mismatch();
        test_timeout();
        test_late_valid();
        test_proto_err();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
